// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared types for the register bus master
package reg_bus_pkg;

  localparam int REG_DWIDTH = 8;
  localparam int REG_AWIDTH = 8;

  // Bus opcode; 2'b11 is reserved and never driven
  typedef enum logic [1:0] {
    NOP = 2'b00,
    RD  = 2'b01,
    WR  = 2'b10
  } reg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RSP
  } state_e;

  // Request record at the default bus widths
  typedef struct packed {
    logic                  write;
    logic [REG_AWIDTH-1:0] addr;
    logic [REG_DWIDTH-1:0] wdata;
  } reg_req_t;

  function automatic reg_op_e op_for(input logic write);
    return write ? WR : RD;
  endfunction

endpackage

// File: rtl/reg_bus_master_if.sv
// rtl/reg_bus_master_if.sv - request, response and register bus signals
interface reg_bus_master_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
);
  import reg_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DWIDTH-1:0] rsp_rdata;
  reg_op_e           reg_op;
  logic [AWIDTH-1:0] reg_addr;
  logic [DWIDTH-1:0] reg_wdata;
  logic [DWIDTH-1:0] reg_rdata;
  logic              busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, reg_rdata,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, reg_op, reg_addr, reg_wdata, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, reg_rdata,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, reg_op, reg_addr, reg_wdata, busy
  );

endinterface

// File: rtl/reg_req_fifo.sv
// rtl/reg_req_fifo.sv - request FIFO with head read-through and full/empty flags
module reg_req_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset discards all queued entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - queues requests and issues them one at a time on the register bus
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int DWIDTH     = REG_DWIDTH,
  parameter int AWIDTH     = REG_AWIDTH,
  parameter int DEPTH      = 4,
  parameter int RD_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  reg_bus_master_if.master bus
);
  localparam int REQ_W = 1 + AWIDTH + DWIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [REQ_W-1:0]  fifo_wdata, fifo_rdata;
  logic [CW-1:0]     fifo_count, fifo_count_d;
  logic              head_write;
  logic [AWIDTH-1:0] head_addr;
  logic [DWIDTH-1:0] head_wdata;

  state_e            state_q;
  reg_op_e           op_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              wr_q;
  logic [2:0]        cnt_q;
  logic              rsp_valid_q, rsp_write_q;
  logic [DWIDTH-1:0] rsp_rdata_q;
  logic              busy_q, busy_d;

  // Ready is held low while reset is asserted, independent of the flag state
  assign bus.req_ready = !fifo_full && !rst;
  assign fifo_push     = bus.req_valid && bus.req_ready;
  assign fifo_pop      = (state_q == ST_IDLE) && !fifo_empty;
  assign fifo_wdata    = {bus.req_write, bus.req_addr, bus.req_wdata};
  assign head_write    = fifo_rdata[REQ_W-1];
  assign head_addr     = fifo_rdata[DWIDTH +: AWIDTH];
  assign head_wdata    = fifo_rdata[DWIDTH-1:0];

  reg_req_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // busy reflects the queue and FSM as they will be after the coming edge
  always_comb begin
    fifo_count_d = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    busy_d       = (fifo_count_d != '0);
    case (state_q)
      ST_IDLE:           busy_d = busy_d || !fifo_empty;
      ST_ISSUE, ST_WAIT: busy_d = 1'b1;
      ST_RSP:            busy_d = busy_d || !bus.rsp_ready;
      default:           busy_d = busy_d;
    endcase
  end

  // Transaction FSM: pop, single-cycle strobe, read wait, hold response until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            op_q    <= op_for(head_write);
            addr_q  <= head_addr;
            wdata_q <= head_wdata;
            wr_q    <= head_write;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          op_q <= NOP;
          if (wr_q) begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= ST_RSP;
          end else begin
            cnt_q   <= 3'(RD_LATENCY);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 3'd1) begin
            rsp_rdata_q <= bus.reg_rdata;
            rsp_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.reg_op    = op_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - directed bench for reg_bus_master with two-register target models
module tb_reg_bus_master;
  import reg_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  reg_bus_master_if #(.DWIDTH(8), .AWIDTH(8)) bus ();
  reg_bus_master_if #(.DWIDTH(8), .AWIDTH(8)) bus3 ();

  reg_bus_master #(.DWIDTH(8), .AWIDTH(8), .DEPTH(4), .RD_LATENCY(1)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  reg_bus_master #(.DWIDTH(8), .AWIDTH(8), .DEPTH(4), .RD_LATENCY(3)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  // Two-register targets; read data is valid only RD_LATENCY cycles after the strobe
  logic [7:0] regs1 [2];
  logic [7:0] pipe1;
  logic [7:0] regs3 [2];
  logic [7:0] pipe3 [3];
  always @(posedge clk) begin
    if (bus.reg_op == WR) regs1[bus.reg_addr[0]] <= bus.reg_wdata;
    pipe1 <= (bus.reg_op == RD) ? regs1[bus.reg_addr[0]] : 8'hEE;
    if (bus3.reg_op == WR) regs3[bus3.reg_addr[0]] <= bus3.reg_wdata;
    pipe3[0] <= (bus3.reg_op == RD) ? regs3[bus3.reg_addr[0]] : 8'hEE;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus.reg_rdata  = pipe1;
  assign bus3.reg_rdata = pipe3[2];

  // Strobe and response logs for the RD_LATENCY=1 instance
  int         strobes = 0;
  logic [1:0] op_log   [$];
  logic [7:0] addr_log [$];
  logic [8:0] rsp_log  [$];
  always @(posedge clk) begin
    if (!rst && bus.reg_op != NOP) begin
      strobes <= strobes + 1;
      op_log.push_back(bus.reg_op);
      addr_log.push_back(bus.reg_addr);
    end
    if (!rst && bus.rsp_valid && bus.rsp_ready) rsp_log.push_back({bus.rsp_write, bus.rsp_rdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.req_write = w; bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic push3(input logic w, input logic [7:0] a, input logic [7:0] d);
    bus3.req_write = w; bus3.req_addr = a; bus3.req_wdata = d; bus3.req_valid = 1'b1;
    tick();
    bus3.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 1;
    bus3.req_valid = 0; bus3.req_write = 0; bus3.req_addr = 0; bus3.req_wdata = 0; bus3.rsp_ready = 1;
    rst = 1'b1;
    repeat (3) tick();
    n_vec++; if (bus.reg_op !== NOP) begin n_err++; $display("FAIL reset_reg_op got %0d want 0", bus.reg_op); end
    n_vec++; if (bus.reg_addr !== 8'h00) begin n_err++; $display("FAIL reset_reg_addr got %h want 00", bus.reg_addr); end
    n_vec++; if (bus.reg_wdata !== 8'h00) begin n_err++; $display("FAIL reset_reg_wdata got %h want 00", bus.reg_wdata); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_vec++; if (bus.rsp_write !== 1'b0) begin n_err++; $display("FAIL reset_rsp_write got %b want 0", bus.rsp_write); end
    n_vec++; if (bus.rsp_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rsp_rdata got %h want 00", bus.rsp_rdata); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
    rst = 1'b0;
    #1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL release_req_ready got %b want 1", bus.req_ready); end
    tick();
  endtask

  task automatic test_write();
    bus.rsp_ready = 1;
    push(1'b1, 8'h00, 8'hA5);
    tick();
    n_vec++; if (bus.reg_op !== WR) begin n_err++; $display("FAIL wr_strobe_op got %0d want 2", bus.reg_op); end
    n_vec++; if (bus.reg_addr !== 8'h00) begin n_err++; $display("FAIL wr_strobe_addr got %h want 00", bus.reg_addr); end
    n_vec++; if (bus.reg_wdata !== 8'hA5) begin n_err++; $display("FAIL wr_strobe_wdata got %h want a5", bus.reg_wdata); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_early_rsp got %b want 0", bus.rsp_valid); end
    tick();
    n_vec++; if (bus.reg_op !== NOP) begin n_err++; $display("FAIL wr_strobe_len got %0d want 0", bus.reg_op); end
    n_vec++; if ({bus.rsp_valid, bus.rsp_write, bus.rsp_rdata} !== {2'b11, 8'h00}) begin
      n_err++; $display("FAIL wr_rsp got v=%b w=%b d=%h want v=1 w=1 d=00", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata);
    end
    tick();
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_rsp_clear got %b want 0", bus.rsp_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_after got %b want 0", bus.busy); end
  endtask

  task automatic test_read();
    bus.rsp_ready = 1;
    push(1'b0, 8'h00, 8'h00);
    tick();
    n_vec++; if (bus.reg_op !== RD) begin n_err++; $display("FAIL rd_strobe_op got %0d want 1", bus.reg_op); end
    tick();
    n_vec++; if (bus.reg_op !== NOP) begin n_err++; $display("FAIL rd_strobe_len got %0d want 0", bus.reg_op); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_early_rsp got %b want 0", bus.rsp_valid); end
    tick();
    n_vec++; if ({bus.rsp_valid, bus.rsp_write, bus.rsp_rdata} !== {2'b10, 8'hA5}) begin
      n_err++; $display("FAIL rd_rsp got v=%b w=%b d=%h want v=1 w=0 d=a5", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic       w [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] a [5] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
    logic [7:0] d [5] = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    logic [8:0] exp_rsp [5] = '{9'h100, 9'h100, 9'h011, 9'h022, 9'h011};
    logic [1:0] exp_op  [5] = '{WR, WR, RD, RD, RD};
    int s0 = strobes;
    int r0 = rsp_log.size();
    int o0 = op_log.size();
    int g;
    bus.rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.req_write = w[i]; bus.req_addr = a[i]; bus.req_wdata = d[i]; bus.req_valid = 1'b1;
      g = 0;
      while (!bus.req_ready && g < 20) begin tick(); g++; end
      n_vec++; if (g != 0) begin n_err++; $display("FAIL b2b_accept_%0d waited %0d cycles want 0", i, g); end
      tick();
    end
    bus.req_valid = 1'b0;
    n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready got %b want 0", bus.req_ready); end
    repeat (5) tick();
    n_vec++; if (strobes - s0 != 1) begin n_err++; $display("FAIL b2b_strobes got %0d want 1", strobes - s0); end
    n_vec++; if ({bus.rsp_valid, bus.rsp_write, bus.busy} !== 3'b111) begin
      n_err++; $display("FAIL b2b_held_rsp got v=%b w=%b busy=%b want 1 1 1", bus.rsp_valid, bus.rsp_write, bus.busy);
    end
    bus.rsp_ready = 1;
    g = 0;
    while (rsp_log.size() - r0 < 5 && g < 100) begin tick(); g++; end
    n_vec++; if (rsp_log.size() - r0 != 5) begin n_err++; $display("FAIL b2b_drain got %0d responses want 5", rsp_log.size() - r0); end
    for (int i = 0; i < 5 && r0 + i < rsp_log.size() && o0 + i < op_log.size(); i++) begin
      n_vec++; if (rsp_log[r0+i] !== exp_rsp[i]) begin n_err++; $display("FAIL b2b_rsp_%0d got %h want %h", i, rsp_log[r0+i], exp_rsp[i]); end
      n_vec++; if ({op_log[o0+i], addr_log[o0+i]} !== {exp_op[i], a[i]}) begin
        n_err++; $display("FAIL b2b_op_%0d got op=%0d addr=%h want op=%0d addr=%h", i, op_log[o0+i], addr_log[o0+i], exp_op[i], a[i]);
      end
    end
    tick();
  endtask

  task automatic test_hold();
    int r0 = rsp_log.size();
    int g = 0;
    bus.rsp_ready = 0;
    push(1'b0, 8'h01, 8'h00);
    push(1'b1, 8'h00, 8'h5A);
    while (!bus.rsp_valid && g < 20) begin tick(); g++; end
    n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL hold_rsp_arrive got %b want 1", bus.rsp_valid); end
    for (int i = 0; i < 10; i++) begin
      n_vec++; if ({bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.reg_op} !== {2'b10, 8'h22, NOP}) begin
        n_err++; $display("FAIL hold_cycle_%0d got v=%b w=%b d=%h op=%0d want v=1 w=0 d=22 op=0", i, bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.reg_op);
      end
      tick();
    end
    bus.rsp_ready = 1;
    g = 0;
    while (rsp_log.size() - r0 < 2 && g < 20) begin tick(); g++; end
    n_vec++; if (rsp_log.size() - r0 != 2) begin n_err++; $display("FAIL hold_drain got %0d responses want 2", rsp_log.size() - r0); end
    else begin
      n_vec++; if ({rsp_log[r0], rsp_log[r0+1]} !== {9'h022, 9'h100}) begin
        n_err++; $display("FAIL hold_rsp_order got %h %h want 022 100", rsp_log[r0], rsp_log[r0+1]);
      end
    end
    tick();
  endtask

  task automatic test_latency3();
    int g = 0;
    bus3.rsp_ready = 1;
    push3(1'b1, 8'h01, 8'h3C);
    while (!bus3.rsp_valid && g < 20) begin tick(); g++; end
    n_vec++; if ({bus3.rsp_valid, bus3.rsp_write} !== 2'b11) begin n_err++; $display("FAIL lat3_wr_rsp got v=%b w=%b want 1 1", bus3.rsp_valid, bus3.rsp_write); end
    tick();
    push3(1'b0, 8'h01, 8'h00);
    g = 0;
    while (bus3.reg_op !== RD && g < 20) begin tick(); g++; end
    n_vec++; if (bus3.reg_op !== RD) begin n_err++; $display("FAIL lat3_strobe got %0d want 1", bus3.reg_op); end
    g = 0;
    while (!bus3.rsp_valid && g < 20) begin tick(); g++; end
    n_vec++; if (g != 4) begin n_err++; $display("FAIL lat3_latency got %0d cycles want 4", g); end
    n_vec++; if ({bus3.rsp_write, bus3.rsp_rdata} !== {1'b0, 8'h3C}) begin
      n_err++; $display("FAIL lat3_rdata got w=%b d=%h want w=0 d=3c", bus3.rsp_write, bus3.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int r0 = rsp_log.size();
    int s0 = strobes;
    bus.rsp_ready = 1;
    bus.req_write = 0; bus.req_addr = 8'h01; bus.req_wdata = 8'h5A; bus.req_valid = 1;
    tick();
    bus.req_write = 1; bus.req_addr = 8'h00; bus.req_wdata = 8'h99;
    tick();
    bus.req_write = 1; bus.req_addr = 8'h01; bus.req_wdata = 8'h66;
    tick();
    bus.req_valid = 0;
    n_vec++; if ({bus.busy, bus.reg_addr, bus.reg_wdata} !== {1'b1, 8'h01, 8'h5A}) begin
      n_err++; $display("FAIL mid_pre got busy=%b addr=%h wdata=%h want 1 01 5a", bus.busy, bus.reg_addr, bus.reg_wdata);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({bus.reg_op, bus.reg_addr, bus.reg_wdata} !== {NOP, 8'h00, 8'h00}) begin
      n_err++; $display("FAIL mid_async_bus got op=%0d addr=%h wdata=%h want 0 00 00", bus.reg_op, bus.reg_addr, bus.reg_wdata);
    end
    n_vec++; if ({bus.rsp_valid, bus.busy, bus.req_ready} !== 3'b000) begin
      n_err++; $display("FAIL mid_async_ctl got v=%b busy=%b ready=%b want 0 0 0", bus.rsp_valid, bus.busy, bus.req_ready);
    end
    repeat (2) tick();
    rst = 1'b0;
    #1;
    n_vec++; if ({bus.busy, bus.req_ready} !== 2'b01) begin n_err++; $display("FAIL mid_release got busy=%b ready=%b want 0 1", bus.busy, bus.req_ready); end
    repeat (10) tick();
    n_vec++; if (rsp_log.size() != r0) begin n_err++; $display("FAIL mid_no_rsp got %0d responses want 0", rsp_log.size() - r0); end
    n_vec++; if (strobes - s0 != 1) begin n_err++; $display("FAIL mid_strobes got %0d want 1", strobes - s0); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_after got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_hold();
    test_latency3();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

endmodule
